// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared types and constants for the ALU arbiter.
// Holds the arbiter state enum, the MIPS opcodes the arbiter must
// recognise, the requester count, and small decode helpers.
package alu_arb_pkg;

   localparam int NREQ = 2;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   // The ALU only defines its branch output for BEQ/BNE.
   function automatic logic is_branch_op(input logic [5:0] opcode);
      return (opcode == OP_BEQ) || (opcode == OP_BNE);
   endfunction

   // Port index to one-hot port mask.
   function automatic logic [NREQ-1:0] port_onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester-side request/response bundle of the ALU arbiter.
// master = the requesters (issue + branch paths), slave = the arbiter.
interface alu_arbiter_if
   import alu_arb_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int TAG_W  = 4
);

   logic [NREQ-1:0]             req_valid;
   logic [NREQ-1:0]             req_ready;
   logic [NREQ-1:0][5:0]        req_opcode;
   logic [NREQ-1:0][5:0]        req_funct;
   logic [NREQ-1:0][4:0]        req_shamt;
   logic [NREQ-1:0][15:0]       req_imm;
   logic [NREQ-1:0][DATA_W-1:0] req_rs;
   logic [NREQ-1:0][DATA_W-1:0] req_rt;
   logic [NREQ-1:0][TAG_W-1:0]  req_tag;

   logic [NREQ-1:0]             rsp_valid;
   logic [NREQ-1:0]             rsp_ready;
   logic [DATA_W-1:0]           rsp_result;
   logic                        rsp_branch;
   logic [TAG_W-1:0]            rsp_tag;

   modport master (
      output req_valid, req_opcode, req_funct, req_shamt, req_imm,
             req_rs, req_rt, req_tag, rsp_ready,
      input  req_ready, rsp_valid, rsp_result, rsp_branch, rsp_tag
   );

   modport slave (
      input  req_valid, req_opcode, req_funct, req_shamt, req_imm,
             req_rs, req_rt, req_tag, rsp_ready,
      output req_ready, rsp_valid, rsp_result, rsp_branch, rsp_tag
   );

endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-way grant selection for the ALU arbiter.
// Default: round-robin on contention (grant the port that did not win last).
// ALU_ARB_FIXED_PRIO_EN defined: port 0 always wins contention and
// last_grant is ignored.
module rr_arb2 (
   input  logic [1:0] valid,
   input  logic       last_grant,
   output logic [1:0] grant
);

`ifdef ALU_ARB_FIXED_PRIO_EN
   logic unused_last_grant_s;
   assign unused_last_grant_s = last_grant;
`endif

   // One-hot grant: a lone requester always wins, contention is resolved by policy.
   always_comb begin
      grant = 2'b00;
      case (valid)
         2'b01: grant = 2'b01;
         2'b10: grant = 2'b10;
         2'b11: begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            grant = 2'b01;
`else
            if (last_grant) begin
               grant = 2'b01;
            end else begin
               grant = 2'b10;
            end
`endif
         end
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational MIPS ALU between the integer
// execute path (port 0) and the branch-resolution path (port 1).
// One operation in flight: IDLE (grant) -> EXEC (ALU evaluates the
// registered operands) -> RESP (result held until the owner accepts).
// Contention policy comes from rr_arb2 (see ALU_ARB_FIXED_PRIO_EN).
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int TAG_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   alu_arbiter_if.slave      bus,
   output logic [5:0]        alu_opcode,
   output logic [5:0]        alu_funct,
   output logic [4:0]        alu_shamt,
   output logic [15:0]       alu_imm,
   output logic [DATA_W-1:0] alu_rs,
   output logic [DATA_W-1:0] alu_rt,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_branch
);

   state_t              state_r;
   state_t              state_n_s;
   logic [NREQ-1:0]     grant_s;
   logic                grant_idx_s;
   logic                accept_s;
   logic                owner_r;
   logic                last_grant_r;
   logic [5:0]          opcode_r;
   logic [5:0]          funct_r;
   logic [4:0]          shamt_r;
   logic [15:0]         imm_r;
   logic [DATA_W-1:0]   rs_r;
   logic [DATA_W-1:0]   rt_r;
   logic [TAG_W-1:0]    tag_r;
   logic [DATA_W-1:0]   result_r;
   logic                branch_r;
   logic [NREQ-1:0]     rsp_valid_r;

   rr_arb2 u_rr_arb2 (
      .valid      (bus.req_valid),
      .last_grant (last_grant_r),
      .grant      (grant_s)
   );

   assign grant_idx_s = grant_s[1];
   assign accept_s    = (state_r == IDLE) && (|bus.req_valid);

   // Offer the grant only while idle and out of reset.
   always_comb begin
      if (rst_n && (state_r == IDLE)) begin
         bus.req_ready = grant_s;
      end else begin
         bus.req_ready = 2'b00;
      end
   end

   // Next-state: one operation flows IDLE -> EXEC -> RESP -> IDLE.
   always_comb begin
      state_n_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_n_s = EXEC;
            end else begin
               state_n_s = IDLE;
            end
         end
         EXEC: state_n_s = RESP;
         RESP: begin
            if (bus.rsp_ready[owner_r]) begin
               state_n_s = IDLE;
            end else begin
               state_n_s = RESP;
            end
         end
         default: state_n_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_n_s;
      end
   end

   // Operand latch on accept, result/branch capture in EXEC, response valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_r      <= 1'b0;
         last_grant_r <= 1'b1;
         opcode_r     <= 6'h00;
         funct_r      <= 6'h00;
         shamt_r      <= 5'h00;
         imm_r        <= 16'h0000;
         rs_r         <= '0;
         rt_r         <= '0;
         tag_r        <= '0;
         result_r     <= '0;
         branch_r     <= 1'b0;
         rsp_valid_r  <= 2'b00;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  owner_r      <= grant_idx_s;
                  last_grant_r <= grant_idx_s;
                  opcode_r     <= bus.req_opcode[grant_idx_s];
                  funct_r      <= bus.req_funct[grant_idx_s];
                  shamt_r      <= bus.req_shamt[grant_idx_s];
                  imm_r        <= bus.req_imm[grant_idx_s];
                  rs_r         <= bus.req_rs[grant_idx_s];
                  rt_r         <= bus.req_rt[grant_idx_s];
                  tag_r        <= bus.req_tag[grant_idx_s];
               end
            end
            EXEC: begin
               result_r    <= alu_result;
               // ALU branch output is undefined for non-branch opcodes.
               branch_r    <= is_branch_op(opcode_r) ? alu_branch : 1'b0;
               rsp_valid_r <= port_onehot(owner_r);
            end
            RESP: begin
               if (bus.rsp_ready[owner_r]) begin
                  rsp_valid_r <= 2'b00;
               end
            end
            default: rsp_valid_r <= 2'b00;
         endcase
      end
   end

   assign alu_opcode     = opcode_r;
   assign alu_funct      = funct_r;
   assign alu_shamt      = shamt_r;
   assign alu_imm        = imm_r;
   assign alu_rs         = rs_r;
   assign alu_rt         = rt_r;
   assign bus.rsp_valid  = rsp_valid_r;
   assign bus.rsp_result = result_r;
   assign bus.rsp_branch = branch_r;
   assign bus.rsp_tag    = tag_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with a behavioural ALU stub.
// Build with ALU_ARB_FIXED_PRIO_EN to check the fixed-priority variant.
module tb_alu_arbiter;
   import alu_arb_pkg::*;

   typedef struct {
      int          port;
      logic [31:0] res;
      logic        br;
      logic [3:0]  tag;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [5:0]  alu_opcode;
   logic [5:0]  alu_funct;
   logic [4:0]  alu_shamt;
   logic [15:0] alu_imm;
   logic [31:0] alu_rs;
   logic [31:0] alu_rt;
   logic [31:0] alu_result;
   logic        alu_branch;
   logic        stale_br;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t sb_q[$];
   logic [1:0] exp_g [3];

   alu_arbiter_if #(.DATA_W(32), .TAG_W(4)) bus ();

   alu_arbiter #(.DATA_W(32), .TAG_W(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .alu_opcode (alu_opcode),
      .alu_funct  (alu_funct),
      .alu_shamt  (alu_shamt),
      .alu_imm    (alu_imm),
      .alu_rs     (alu_rs),
      .alu_rt     (alu_rt),
      .alu_result (alu_result),
      .alu_branch (alu_branch)
   );

   always #5 clk = ~clk;

   // Behavioural ALU; branch output for non-branch opcodes follows stale_br.
   always_comb begin
      alu_result = 32'hDEAD_BEEF;
      alu_branch = stale_br;
      case (alu_opcode)
         OP_RTYPE: begin
            case (alu_funct)
               6'h00:   alu_result = alu_rt << alu_shamt;
               6'h20:   alu_result = alu_rs + alu_rt;
               6'h22:   alu_result = alu_rs - alu_rt;
               6'h25:   alu_result = alu_rs | alu_rt;
               default: alu_result = 32'hDEAD_BEEF;
            endcase
         end
         6'h0d:  alu_result = alu_rs | {16'h0000, alu_imm};
         OP_BEQ: begin
            alu_result = alu_rs - alu_rt;
            alu_branch = (alu_rs == alu_rt);
         end
         OP_BNE: begin
            alu_result = alu_rs - alu_rt;
            alu_branch = (alu_rs != alu_rt);
         end
         default: alu_result = 32'hDEAD_BEEF;
      endcase
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] oh(input int p);
      return (p == 1) ? 2'b10 : 2'b01;
   endfunction

   task automatic set_req(input int p, input logic [5:0] op, input logic [5:0] fn,
                          input logic [15:0] imm, input logic [31:0] rs,
                          input logic [31:0] rt, input logic [3:0] tag);
      bus.req_opcode[p] = op;
      bus.req_funct[p]  = fn;
      bus.req_shamt[p]  = 5'd0;
      bus.req_imm[p]    = imm;
      bus.req_rs[p]     = rs;
      bus.req_rt[p]     = rt;
      bus.req_tag[p]    = tag;
      bus.req_valid[p]  = 1'b1;
   endtask

   // Waits (bounded) for req_ready[p], then passes the accepting edge.
   task automatic wait_accept(input int p, output logic got);
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         if (bus.req_ready[p]) got = 1'b1;
         else begin
            @(negedge clk);
            #1;
         end
      end
      chk("accept_timeout", {63'd0, got}, 64'd1);
      if (got) begin
         @(posedge clk);
         #1;
      end
      bus.req_valid[p] = 1'b0;
   endtask

   task automatic check_rsp();
      exp_t e;
      if (sb_q.size() == 0) begin
         chk("sb_underflow", 64'd1, 64'd0);
      end else begin
         e = sb_q.pop_front();
         chk("rsp_valid", bus.rsp_valid, oh(e.port));
         chk("rsp_result", bus.rsp_result, e.res);
         chk("rsp_branch", bus.rsp_branch, e.br);
         chk("rsp_tag", bus.rsp_tag, e.tag);
      end
   endtask

   // Full operation from IDLE: accept, no response in EXEC, response next cycle.
   task automatic run_op(input int p, input logic [5:0] op, input logic [5:0] fn,
                         input logic [15:0] imm, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [3:0] tag,
                         input logic [31:0] exp_res, input logic exp_br);
      logic got;
      sb_q.push_back('{port: p, res: exp_res, br: exp_br, tag: tag});
      @(negedge clk);
      set_req(p, op, fn, imm, rs, rt, tag);
      #1;
      chk("ready_in_idle", bus.req_ready, oh(p));
      wait_accept(p, got);
      if (!got) begin
         void'(sb_q.pop_back());
      end else begin
         @(negedge clk);
         #1;
         chk("exec_rsp_valid", bus.rsp_valid, 2'b00);
         chk("exec_req_ready", bus.req_ready, 2'b00);
         @(negedge clk);
         #1;
         check_rsp();
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic got;
      logic [31:0] c_res [2];
      logic [3:0]  c_tag [2];
      int p;

`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01;
`else
      exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
`endif
      c_res[0] = 32'd30;  c_tag[0] = 4'h5;
      c_res[1] = 32'd101; c_tag[1] = 4'h9;

      rst_n         = 1'b0;
      stale_br      = 1'b0;
      bus.req_valid = 2'b00;
      bus.rsp_ready = 2'b11;
      for (int i = 0; i < 2; i++) set_req(i, 6'h00, 6'h00, 16'h0, 32'h0, 32'h0, 4'h0);
      bus.req_valid = 2'b01;

      // Reset values, with a request pending.
      repeat (2) @(negedge clk);
      #1;
      chk("rst_req_ready", bus.req_ready, 2'b00);
      chk("rst_rsp_valid", bus.rsp_valid, 2'b00);
      chk("rst_rsp_result", bus.rsp_result, 32'h0);
      chk("rst_rsp_tag", bus.rsp_tag, 4'h0);
      chk("rst_alu_opcode", alu_opcode, 6'h00);
      bus.req_valid = 2'b00;
      @(negedge clk);
      rst_n = 1'b1;

      // Contention in three consecutive IDLE windows.
      @(negedge clk);
      set_req(0, OP_RTYPE, 6'h20, 16'h0, 32'd10, 32'd20, 4'h5);
      set_req(1, OP_RTYPE, 6'h20, 16'h0, 32'd100, 32'd1, 4'h9);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("cont_grant", bus.req_ready, exp_g[i]);
         p = exp_g[i][1] ? 1 : 0;
         sb_q.push_back('{port: p, res: c_res[p], br: 1'b0, tag: c_tag[p]});
         @(posedge clk);
         @(negedge clk);
         #1;
         chk("cont_exec_req_ready", bus.req_ready, 2'b00);
         @(negedge clk);
         #1;
         check_rsp();
         @(negedge clk);
         #1;
      end
      bus.req_valid = 2'b00;

      // Single ADD on port 0.
      run_op(0, OP_RTYPE, 6'h20, 16'h0, 32'd5, 32'd7, 4'h3, 32'd12, 1'b0);

      // Branch capture, then ORI with a stale high branch signal.
      run_op(1, OP_BEQ, 6'h00, 16'h0, 32'h1234, 32'h1234, 4'h6, 32'h0, 1'b1);
      stale_br = 1'b1;
      run_op(1, 6'h0d, 6'h00, 16'h00ff, 32'h1000, 32'h0, 4'h8, 32'h10ff, 1'b0);
      // Unsupported opcode passes through unflagged.
      run_op(0, 6'h3f, 6'h00, 16'h0, 32'h1, 32'h2, 4'hc, 32'hDEAD_BEEF, 1'b0);
      stale_br = 1'b0;

      // Backpressure on port 1 for 5 cycles, port 0 requesting meanwhile.
      bus.rsp_ready = 2'b00;
      sb_q.push_back('{port: 1, res: 32'd42, br: 1'b0, tag: 4'h7});
      @(negedge clk);
      set_req(1, OP_RTYPE, 6'h22, 16'h0, 32'd50, 32'd8, 4'h7);
      #1;
      wait_accept(1, got);
      @(negedge clk);
      @(negedge clk);
      #1;
      check_rsp();
      set_req(0, OP_RTYPE, 6'h20, 16'h0, 32'd3, 32'd4, 4'h2);
      bus.rsp_ready[0] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         #1;
         chk("bp_rsp_valid", bus.rsp_valid, 2'b10);
         chk("bp_rsp_result", bus.rsp_result, 32'd42);
         chk("bp_rsp_tag", bus.rsp_tag, 4'h7);
         chk("bp_req_ready", bus.req_ready, 2'b00);
      end
      bus.rsp_ready = 2'b11;
      @(posedge clk);
      #1;
      chk("bp_regrant", bus.req_ready, 2'b01);
      bus.req_valid = 2'b00;
      run_op(0, OP_RTYPE, 6'h20, 16'h0, 32'd3, 32'd4, 4'h2, 32'd7, 1'b0);

      // Reset during EXEC discards the operation.
      @(negedge clk);
      set_req(0, OP_RTYPE, 6'h25, 16'h0, 32'hf0, 32'h0f, 4'h4);
      #1;
      wait_accept(0, got);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_rsp_valid", bus.rsp_valid, 2'b00);
      chk("mid_rst_rsp_tag", bus.rsp_tag, 4'h0);
      chk("mid_rst_rsp_result", bus.rsp_result, 32'h0);
      chk("mid_rst_alu_rs", alu_rs, 32'h0);
      chk("mid_rst_req_ready", bus.req_ready, 2'b00);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(1, OP_RTYPE, 6'h20, 16'h0, 32'h10, 32'h20, 4'ha, 32'h30, 1'b0);

      chk("sb_drained", sb_q.size(), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational 32-bit MIPS ALU between two requesters (port 0: integer execute path, port 1: branch-resolution path). Accepts one operation at a time through a valid/ready handshake, drives the ALU from registered operands, captures the result, and returns it with the requester's tag on that requester's response channel. Sits between the decode/issue logic and the shared ALU instance in the datapath.

## Interface
- DATA_W, 32, operand/result width
- TAG_W, 4, opaque requester tag echoed with the result

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  per-port request valid
- req_ready  out  2  per-port request accept
- req_opcode  in  2x6  per-port opcode
- req_funct  in  2x6  per-port funct
- req_shamt  in  2x5  per-port shift amount
- req_imm  in  2x16  per-port immediate
- req_rs  in  2xDATA_W  per-port rs content
- req_rt  in  2xDATA_W  per-port rt content
- req_tag  in  2xTAG_W  per-port tag
- rsp_valid  out  2  per-port response valid
- rsp_ready  in  2  per-port response accept
- rsp_result  out  DATA_W  result of the in-flight operation, shared by both ports
- rsp_branch  out  1  branch-taken flag, shared
- rsp_tag  out  TAG_W  echoed tag, shared
- alu_opcode, alu_funct, alu_shamt, alu_imm, alu_rs, alu_rt  out  6/6/5/16/DATA_W/DATA_W  registered operands to the ALU
- alu_result  in  DATA_W  ALU result
- alu_branch  in  1  ALU branch signal

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any req_valid, the arbiter grants exactly one port. Grant is combinational: req_ready[g]=1 only for the granted port, 0 elsewhere. On the handshake, latch opcode/funct/shamt/imm/rs/rt/tag and the owner index g, update last_grant=g, then go to EXEC.
- Round-robin: if both ports are valid, grant !last_grant. If one port is valid, grant that port. last_grant resets to 1, so port 0 wins the first contention.
- EXEC: alu_* outputs hold the latched operands for the whole cycle. At the end of the cycle, capture alu_result into the result register. Capture alu_branch only when the opcode is 6'h04 or 6'h05; otherwise the branch register is 0. The ALU does not define its branch output for other opcodes, so it must not be sampled for them. Go to RESP.
- RESP: rsp_valid[owner]=1, other bit 0. rsp_result, rsp_branch and rsp_tag are stable until the handshake. When rsp_ready[owner] is high, go to IDLE. rsp_ready of the non-owner is ignored.
- req_ready=0 in EXEC and RESP. Requesters must hold valid and payload until accepted. req_valid must not depend on req_ready.
- Unsupported opcodes/funct codes pass through unchanged. The result is whatever the ALU drives, and nothing is flagged.

## Timing
- Reset values: req_ready=0 while rst_n is low, then combinational per the rules above. rsp_valid=0, rsp_result=0, rsp_branch=0, rsp_tag=0, all alu_* outputs 0, state=IDLE, last_grant=1.
- Latency: accept at edge N, EXEC during cycle N+1, rsp_valid high in cycle N+2. Minimum spacing is 3 cycles per operation.
- Backpressure: RESP holds indefinitely while rsp_ready[owner]=0.
- Simultaneous events: a new req_valid during RESP is ignored until IDLE. Port 1 being valid in the cycle port 0 is accepted does not change that grant.
- Reset mid-operation: asserting rst_n low in EXEC or RESP drops rsp_valid immediately (async) and discards the in-flight operation. Requesters re-issue after reset.

## Configuration
- ALU_ARB_FIXED_PRIO_EN defined: port 0 always wins contention. last_grant is still maintained but unused for the decision.
- ALU_ARB_FIXED_PRIO_EN undefined (default): round-robin as in Operation.

## Structure
- Package alu_arb_pkg holds:
  - the state enum (IDLE, EXEC, RESP);
  - opcode constants OP_RTYPE=6'h00, OP_BEQ=6'h04, OP_BNE=6'h05;
  - the port-count constant NREQ=2.
- One sub-module, rr_arb2: inputs valid[1:0] and last_grant; outputs a one-hot grant. It contains the ALU_ARB_FIXED_PRIO_EN switch.
- The ALU itself is instantiated outside this block.

## Test plan
- Single request, port 0: ADD (opcode 0, funct 6'h20), rs=5, rt=7, tag=3. Required: req_ready[0] in IDLE, rsp_valid[0] two cycles after accept, rsp_result=12, rsp_tag=3, rsp_branch=0.
- Contention: both ports valid in three consecutive IDLE windows. Required grants 0,1,0 by default; 0,0,0 with ALU_ARB_FIXED_PRIO_EN defined.
- Branch capture: port 1 BEQ, rs=rt=0x1234. Required: rsp_branch=1. A following port 1 ORI with a stale ALU branch signal high must return rsp_branch=0.
- Backpressure: hold rsp_ready[owner]=0 for 5 cycles. Required: rsp_valid, rsp_result and rsp_tag stable throughout, req_ready=0, no new grant until release.
- Reset mid-EXEC: pull rst_n low during EXEC. Required: all outputs return to reset values at once, state is IDLE after release, and the next request completes normally.
